// File: rtl/pk_inverse.sv
// Restoring divider that undoes the constant-gain stage: splits pk into yk = pk / A and rem = pk % A,
// producing one quotient bit per clock behind a start/busy/done handshake.
module pk_inverse #(
   parameter int unsigned N = 8,
   parameter int unsigned A = 85
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [2*N-1:0]   pk_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [N-1:0]     yk_o,
   output logic [N-1:0]     rem_o,
   output logic             ovf_o
);

   generate
      if (A == 0 || A >= (2 ** N) || N < 2) begin : gBadParams
         $error("pk_inverse: A must be nonzero and fit in N bits, and N must be at least 2");
      end
   endgenerate

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [N-1:0]  A_N      = N'(A);
   localparam logic [N:0]    A_TRIAL  = (N+1)'(A);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    part_q, part_d;
   logic [N-1:0]    shift_q, shift_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    yk_q, yk_d;
   logic [N-1:0]    rem_q, rem_d;
   logic            ovf_q, ovf_d;

   logic [N:0]      trial;
   logic            qBit;
   logic [N-1:0]    stepRem;
   logic [N-1:0]    stepShift;

   // shift_q starts as the low dividend half and fills with quotient bits as the dividend bits leave
   always_comb begin
      trial     = {part_q, shift_q[N-1]};
      qBit      = (trial >= A_TRIAL);
      stepRem   = qBit ? N'(trial - A_TRIAL) : trial[N-1:0];
      stepShift = {shift_q[N-2:0], qBit};
   end

   always_comb begin
      state_d = state_q;
      part_d  = part_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      yk_d    = yk_q;
      rem_d   = rem_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               ovf_d = 1'b0;
               // A high half of A or more means the quotient cannot fit in N bits
               if (pk_i[2*N-1:N] >= A_N) begin
                  ovf_d   = 1'b1;
                  yk_d    = '1;
                  rem_d   = '0;
                  state_d = DONE;
               end else begin
                  part_d  = pk_i[2*N-1:N];
                  shift_d = pk_i[N-1:0];
                  cnt_d   = CNT_LAST;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            part_d  = stepRem;
            shift_d = stepShift;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               yk_d    = stepShift;
               rem_d   = stepRem;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         part_q  <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
         yk_q    <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         part_q  <= part_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         yk_q    <= yk_d;
         rem_q   <= rem_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy_o = (state_q == RUN);
   assign done_o = (state_q == DONE);
   assign yk_o   = yk_q;
   assign rem_o  = rem_q;
   assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_pk_inverse.sv
// Directed bench for pk_inverse with A=85, N=8: handshake timing, boundaries, back-to-back starts,
// mid-division reset and a random sweep against pk/85 and pk%85.
module tb_pk_inverse;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] pk;
   logic        busy;
   logic        done;
   logic [7:0]  yk;
   logic [7:0]  rem;
   logic        ovf;

   int testCount = 0;
   int failCount = 0;

   pk_inverse #(.N(8), .A(85)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .pk_i    (pk),
      .busy_o  (busy),
      .done_o  (done),
      .yk_o    (yk),
      .rem_o   (rem),
      .ovf_o   (ovf)
   );

   // 100 MHz clock; outputs are sampled on the falling edge
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Runs one division on p and checks latency, busy width, results, output hold and done width
   task automatic applyStimulus(input logic [15:0] p);
      int         expYk, expRem, expOvf, expLat;
      int         lat, busyCnt;
      bit         gotDone, held;
      logic [7:0] prevYk, prevRem;
      expOvf  = (p >= 21760) ? 1 : 0;
      expYk   = expOvf ? 255 : p / 85;
      expRem  = expOvf ? 0 : p % 85;
      expLat  = expOvf ? 0 : 8;
      @(negedge clk);
      prevYk  = yk;
      prevRem = rem;
      pk      = p;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      pk      = 16'($urandom);
      gotDone = 1'b0;
      held    = 1'b1;
      lat     = 0;
      busyCnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) begin
            gotDone = 1'b1;
            lat     = k;
            break;
         end
         if (busy) begin
            busyCnt++;
            if (yk !== prevYk || rem !== prevRem) held = 1'b0;
         end
      end
      checkVal("done arrives", 32'(gotDone), 32'd1);
      checkVal("latency", lat, expLat);
      checkVal("busy cycles", busyCnt, expLat);
      checkVal("busy low at done", 32'(busy), 32'd0);
      checkVal("yk", 32'(yk), expYk);
      checkVal("rem", 32'(rem), expRem);
      checkVal("ovf", 32'(ovf), expOvf);
      checkVal("outputs held while busy", 32'(held), 32'd1);
      if (!ovf) checkVal("rem below A", 32'(rem < 8'd85), 32'd1);
      @(negedge clk);
      checkVal("done one cycle wide", 32'(done), 32'd0);
   endtask

   logic [15:0] vals [0:39];
   bit          extraDone;
   bit          noDone;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      pk    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkVal("reset busy", 32'(busy), 32'd0);
      checkVal("reset done", 32'(done), 32'd0);
      checkVal("reset yk", 32'(yk), 32'd0);
      checkVal("reset rem", 32'(rem), 32'd0);
      checkVal("reset ovf", 32'(ovf), 32'd0);
      rst = 1'b0;

      applyStimulus(16'd3145);
      applyStimulus(16'd3229);
      applyStimulus(16'd0);
      applyStimulus(16'd21759);
      applyStimulus(16'd21760);
      applyStimulus(16'd65535);
      applyStimulus(16'd84);

      // Start held high: accepts at edges 0,10,20,30 and done is seen after edges 8,18,28,38
      for (int i = 0; i < 40; i++) vals[i] = 16'($urandom_range(0, 21759));
      extraDone = 1'b0;
      @(negedge clk);
      pk    = vals[0];
      start = 1'b1;
      for (int c = 0; c < 39; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c % 10 == 8) begin
            checkVal("b2b done", 32'(done), 32'd1);
            checkVal("b2b yk", 32'(yk), 32'(vals[c-8] / 85));
            checkVal("b2b rem", 32'(rem), 32'(vals[c-8] % 85));
            checkVal("b2b ovf", 32'(ovf), 32'd0);
         end else if (done) begin
            extraDone = 1'b1;
         end
         pk = vals[c+1];
      end
      start = 1'b0;
      checkVal("b2b no stray done", 32'(extraDone), 32'd0);
      @(negedge clk);

      // Reset during the fourth RUN cycle, with an ignored start pulse before it
      @(negedge clk);
      pk    = 16'd3229;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      pk    = 16'd100;
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b1;
      @(negedge clk);
      checkVal("abort busy", 32'(busy), 32'd0);
      checkVal("abort done", 32'(done), 32'd0);
      checkVal("abort yk", 32'(yk), 32'd0);
      checkVal("abort rem", 32'(rem), 32'd0);
      checkVal("abort ovf", 32'(ovf), 32'd0);
      rst    = 1'b0;
      noDone = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) noDone = 1'b0;
      end
      checkVal("abort no done follows", 32'(noDone), 32'd1);
      applyStimulus(16'd3145);

      for (int i = 0; i < 1000; i++) applyStimulus(16'($urandom_range(0, 65535)));

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/pk_inverse.md
Name: pk_inverse

Overview:
- Sequential inverse of the constant-gain stage in the filter datapath: recovers yk from a full-width product pk = yk*A + r.
- Computes quotient yk and remainder r by restoring division, one quotient bit per clock.
- Sits on the readback/verification path after the gain stage; it checks and reconstructs sample values without a hardware divider.
- Uses a start/busy/done handshake toward the upstream sample controller.

Parameters:
- N, 8, sample width; the quotient yk and remainder are N bits, the dividend pk is 2N bits.
- A, 8'b01010101 (85), constant gain divisor; must be nonzero and fit in N bits; A=0 is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only in IDLE.
- pk  in  2N  full-width product (dividend); sampled on the edge that accepts start.
- busy  out  1  high while a division is in progress (RUN state).
- done  out  1  single-cycle pulse; yk/rem/ovf valid from this cycle on.
- yk  out  N  quotient pk / A.
- rem  out  N  remainder pk mod A; always < A.
- ovf  out  1  quotient does not fit in N bits (pk >= A*2^N).

Behaviour:
- Reset: all outputs are synchronous.
  - rst=1 at an edge forces state IDLE and clears busy=0, done=0, yk=0, rem=0, ovf=0, the iteration counter and the working registers.
  - rst has priority over everything else, including mid-division; an aborted operation produces no done.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1:
  - latch pk and clear ovf.
  - if pk >= A<<N: set ovf=1, yk=all ones, rem=0, and go to DONE (no iterations).
  - else: load the partial remainder from pk[2N-1:N] (guaranteed < A), load the shift register from pk[N-1:0], set counter=N-1, go to RUN with busy=1.
- RUN: each edge does one restoring step:
  - trial = {partial remainder, next dividend MSB}, which is N+1 bits wide.
  - if trial >= A: the new partial remainder is trial-A and the quotient bit is 1; otherwise the partial remainder is trial and the quotient bit is 0.
  - quotient bits shift in MSB first.
  - when counter==0, register yk/rem, go to DONE, and drop busy.
- DONE: done=1 for exactly one cycle, then return to IDLE unconditionally.
- Latency:
  - normal case: start accepted at edge 0, done high in the cycle after edge N (N clocks).
  - overflow case: done high in the cycle after edge 0 (1 clock).
- Handshake:
  - start is ignored in RUN and DONE; it is not queued.
  - start held high continuously restarts in the IDLE cycle after DONE, re-sampling pk.
  - pk may change freely after acceptance.
- Output hold: yk, rem and ovf keep their last values until the next accepted start. They do not change while busy.
  - they are only guaranteed meaningful from done onward.
- Arithmetic: all compares and subtracts are unsigned at N+1 bits; no sign handling.
- Boundaries:
  - pk=0 gives yk=0, rem=0.
  - pk=A*2^N-1 gives yk=2^N-1, rem=A-1, ovf=0.
  - pk=A*2^N gives ovf=1.

Test Plan:
- Reset, then pk=3145 (85*37), start pulse -> busy high for 8 cycles; done pulse in the 8th cycle after acceptance; yk=37, rem=0, ovf=0.
- pk=3229 (85*37+84) -> yk=37, rem=84, ovf=0; check done is exactly one cycle wide and busy=0 in the done cycle.
- Boundaries:
  - pk=0 -> yk=0, rem=0.
  - pk=21759 -> yk=255, rem=84, ovf=0.
  - pk=21760 -> ovf=1, yk=255, rem=0, done one cycle after acceptance, busy never asserted.
- Start held high with pk changing each cycle -> back-to-back operations; each result matches the pk sampled at its acceptance edge; start pulses during RUN/DONE are ignored.
- Assert rst at the 4th RUN cycle -> next cycle busy=0, done=0, yk=0, rem=0, ovf=0; no done follows; a new start then completes correctly.
- Random sweep: 1000 pk values in [0, 2^16-1] -> compare against a reference model of pk/85 and pk%85 with the overflow rule; rem<85 whenever ovf=0.
